kpn_bcd_adder: RTL

Parametrised fixed-point KPN process node that pops one token from each of two input FIFOs. Each token is a packed BCD value of DIGITS digits. The node converts each operand to binary digit-serially, adds or subtracts the two, saturates to OUT_W bits, and pushes the result into an output FIFO. It replaces the free-running rd/wr toggling of the first-generation adder with real FIFO handshakes, and adds a subtract mode, saturation and BCD-error reporting.

---
 rtl/kpn_bcd_adder_pkg.sv | 21 ++
 rtl/kpn_bcd_adder_bcd_digit_mac.sv | 23 ++
 rtl/kpn_bcd_adder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/kpn_bcd_adder_pkg.sv
// Shared types and helpers for the BCD adder KPN node.
package kpn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        CALC,
        WRITE
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Multiply by ten using shifts only: 8*acc + 2*acc.
    function automatic logic [31:0] times_ten(input logic [31:0] acc);
        return (acc << 3) + (acc << 1);
    endfunction

endpackage

// File: rtl/kpn_bcd_adder_bcd_digit_mac.sv
// One digit-serial BCD-to-binary step: acc_out = acc_in*10 + digit.
// Nibbles above 9 are clamped to 9 and flagged.
module bcd_digit_mac
    import kpn_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       nibble,
    output logic [ACC_W-1:0] acc_out,
    output logic             err
);

    logic [3:0] digit;

    // Clamp invalid digits, then accumulate.
    always_comb begin
        err     = (nibble > BCD_MAX_DIGIT);
        digit   = err ? BCD_MAX_DIGIT : nibble;
        acc_out = ACC_W'(times_ten(32'(acc_in)) + 32'(digit));
    end

endmodule

// File: rtl/kpn_bcd_adder.sv
// KPN process node: pops one BCD token from each input FIFO, converts both
// digit-serially to binary, adds or subtracts, saturates and pushes the result.
module kpn_bcd_adder
    import kpn_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OUT_W  = 16,
    parameter bit          SUB_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   in1_data,
    input  logic                  in1_empty,
    output logic                  in1_rd,
    input  logic [4*DIGITS-1:0]   in2_data,
    input  logic                  in2_empty,
    output logic                  in2_rd,
    output logic [OUT_W-1:0]      out_data,
    input  logic                  out_full,
    output logic                  out_wr,
    output logic                  ovf,
    output logic                  bcd_err
);

    localparam int unsigned IN_W  = 4 * DIGITS;
    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam logic [63:0] SAT   = (64'd1 << OUT_W) - 64'd1;

    state_t            state;
    logic [IN_W-1:0]   op1, op2;
    logic [ACC_W-1:0]  acc1, acc2;
    logic [ACC_W-1:0]  nxt1, nxt2;
    logic              e1, e2;
    logic              err_r;
    logic              mode_r;
    logic [3:0]        cnt;
    logic [OUT_W-1:0]  res_r;
    logic              ovf_r;
    logic [OUT_W-1:0]  calc_res;
    logic              calc_ovf;
    logic [63:0]       a1w, a2w, raw;

    bcd_digit_mac #(.ACC_W(ACC_W)) u_mac1 (
        .acc_in  (acc1),
        .nibble  (op1[IN_W-1 -: 4]),
        .acc_out (nxt1),
        .err     (e1)
    );

    bcd_digit_mac #(.ACC_W(ACC_W)) u_mac2 (
        .acc_in  (acc2),
        .nibble  (op2[IN_W-1 -: 4]),
        .acc_out (nxt2),
        .err     (e2)
    );

    // Add/subtract with low clamp on underflow and high clamp to OUT_W bits.
    always_comb begin
        a1w      = 64'(acc1);
        a2w      = 64'(acc2);
        calc_ovf = 1'b0;
        raw      = a1w + a2w;
        if (mode_r == MODE_SUB) begin
            if (a1w < a2w) begin
                raw      = '0;
                calc_ovf = 1'b1;
            end else begin
                raw = a1w - a2w;
            end
        end
        if (raw > SAT) begin
            raw      = SAT;
            calc_ovf = 1'b1;
        end
        calc_res = OUT_W'(raw);
    end

    // Token FSM: accept, convert MS digit first, compute, write with backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in1_rd   <= 1'b0;
            in2_rd   <= 1'b0;
            out_wr   <= 1'b0;
            ovf      <= 1'b0;
            bcd_err  <= 1'b0;
            out_data <= '0;
            op1      <= '0;
            op2      <= '0;
            acc1     <= '0;
            acc2     <= '0;
            err_r    <= 1'b0;
            mode_r   <= MODE_ADD;
            cnt      <= '0;
            res_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            in1_rd  <= 1'b0;
            in2_rd  <= 1'b0;
            out_wr  <= 1'b0;
            ovf     <= 1'b0;
            bcd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!in1_empty && !in2_empty) begin
                        in1_rd <= 1'b1;
                        in2_rd <= 1'b1;
                        op1    <= in1_data;
                        op2    <= in2_data;
                        mode_r <= SUB_EN ? mode : MODE_ADD;
                        acc1   <= '0;
                        acc2   <= '0;
                        err_r  <= 1'b0;
                        cnt    <= 4'(DIGITS - 1);
                        state  <= CONV;
                    end
                end
                CONV: begin
                    acc1  <= nxt1;
                    acc2  <= nxt2;
                    err_r <= err_r | e1 | e2;
                    op1   <= op1 << 4;
                    op2   <= op2 << 4;
                    if (cnt == 4'd0) state <= CALC;
                    else             cnt   <= cnt - 4'd1;
                end
                CALC: begin
                    res_r <= calc_res;
                    ovf_r <= calc_ovf;
                    state <= WRITE;
                end
                WRITE: begin
                    if (!out_full) begin
                        out_wr   <= 1'b1;
                        out_data <= res_r;
                        ovf      <= ovf_r;
                        bcd_err  <= err_r;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
